branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
Parametrised branch target buffer with per-entry saturating direction counters for the 5-stage RISC-V pipeline. The IF stage looks up the fetch PC and, on a predicted-taken hit, redirects fetch to the stored target. Branch resolution in EX/MEM no longer costs a flush on every taken branch. The resolving stage writes outcomes back, and the block keeps lookup, hit and mispredict performance counters.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, at least 2; IDX_BITS = log2(ENTRIES)
CTR_BITS, 2, direction counter width; 1 gives a last-outcome predictor
MODE, BP_DYNAMIC, BP_STATIC_NT always predicts not-taken; BP_DYNAMIC uses the counters

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
lookup_en  in  1  IF-stage fetch is valid this cycle
lookup_pc  in  32  fetch PC
pred_taken  out  1  predict taken (combinational)
pred_target  out  32  predicted next PC (combinational)
update_en  in  1  a control-flow instruction resolved this cycle
update_pc  in  32  PC of the resolved instruction
update_is_branch  in  1  1 = conditional branch, 0 = JAL/JALR
update_taken  in  1  resolved direction
update_target  in  32  resolved target address
update_mispredict  in  1  datapath flushed for this resolution
perf_lookups  out  32  count of lookup_en cycles
perf_hits  out  32  count of lookups that hit
perf_mispredicts  out  32  count of update_en && update_mispredict

Behaviour:
- Index = pc[IDX_BITS+1:2]; tag = pc[31:IDX_BITS+2]. Each entry holds valid, tag, target[31:0] and ctr[CTR_BITS-1:0].
- Lookup (0-cycle, combinational): hit = valid[idx] && tag match. pred_taken = hit && MODE==BP_DYNAMIC && ctr MSB. pred_target = stored target when pred_taken, else lookup_pc + 4 (32-bit wrap).
- Outputs do not depend on lookup_en; lookup_en only gates perf counting.
- Update (takes effect at the CLK edge when update_en=1):
  - Hit, conditional branch: ctr saturates up if taken, down if not taken. Saturation at 0 and at 2^CTR_BITS-1.
  - Hit, taken (any type): target <= update_target.
  - Hit, JAL/JALR: ctr <= all ones.
  - Miss and taken: allocate, replacing any existing entry at idx (direct-mapped). Set valid=1, tag, target. ctr = 1<<(CTR_BITS-1) for a branch; all ones for JAL/JALR.
  - Miss and not taken: no change.
- The table is updated in both MODEs; MODE affects pred_taken only.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents (read-old). The new contents are visible from the next cycle.
- Perf counters wrap at 2^32. perf_hits increments only when lookup_en && hit.
- Reset (RST=1 at a CLK edge): all valid <= 0, all ctr <= 0, targets and tags don't-care, perf counters <= 0.
  - Any update_en in the same cycle is discarded.
  - Post-reset outputs: pred_taken=0, pred_target=lookup_pc+4.
- No handshake and no stall input. The datapath gates update_en so that each resolved instruction is presented exactly once, including under dhit/ihit stalls.

Decomposition:
- cpu_types_pkg gains bp_mode_t (BP_STATIC_NT, BP_DYNAMIC). Reuse word_t for PCs and targets.
- The entry struct depends on parameters and stays local to the module.
- One sub-module, sat_counter: parametrised CTR_BITS, combinational next-value function with inc/dec/force-max inputs. It is instanced once, on the update path.

Test Plan:
- Reset: ENTRIES=16, CTR_BITS=2, BP_DYNAMIC. After RST, lookup_pc=0x100 -> pred_taken=0, pred_target=0x104, all perf counters 0.
- Allocate: update pc=0x100, branch, taken, target=0x80 -> next cycle lookup 0x100 gives pred_taken=1, pred_target=0x80, ctr=2'b10.
- Hysteresis: two not-taken updates at 0x100 -> ctr 10→01→00, pred_taken=0, pred_target=0x104. A third not-taken update keeps ctr=00. Four taken updates reach 11 and stay there.
- Aliasing: 0x140 maps to the same index 0 as 0x100, so lookup 0x140 misses (pred_target 0x144). Update 0x140 taken, target 0x200 -> lookup 0x140 hits with target 0x200, and lookup 0x100 now misses.
- Collision and reset: same-cycle update and lookup at 0x100 -> lookup shows the old entry and the new one appears next cycle. RST=1 together with update_en=1 -> table clears and the update is dropped.
- Static mode and perf: MODE=BP_STATIC_NT with the same allocation -> pred_taken=0 always. Five lookup_en cycles with 3 hits plus 2 updates with update_mispredict=1 -> perf_lookups=5, perf_hits=3, perf_mispredicts=2.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
//   word_t    : 32-bit machine word, used for PCs and branch targets
//   bp_mode_t : branch predictor operating mode
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    BP_STATIC_NT = 1'b0,
    BP_DYNAMIC   = 1'b1
  } bp_mode_t;

endpackage

// File: rtl/sat_counter.sv
// Combinational next-value for a saturating up/down counter.
// Ports:
//   cnt_i       : current counter value
//   inc_i       : count up, holding at all ones
//   dec_i       : count down, holding at zero
//   force_max_i : load all ones (takes priority over inc/dec)
//   cnt_o       : next counter value
module sat_counter #(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] cnt_i,
  input  logic                inc_i,
  input  logic                dec_i,
  input  logic                force_max_i,
  output logic [CTR_BITS-1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (force_max_i) begin
      cnt_o = '1;
    end else if (inc_i) begin
      if (cnt_i != '1) cnt_o = cnt_i + CTR_BITS'(1);
    end else if (dec_i) begin
      if (cnt_i != '0) cnt_o = cnt_i - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Lookup is combinational from the fetch PC; the resolving stage
// writes outcomes back at the clock edge. Also keeps performance counters.
// Ports:
//   CLK, RST          : clock, synchronous active-high reset
//   lookup_en         : fetch valid this cycle (gates perf counting only)
//   lookup_pc         : fetch PC
//   pred_taken        : predicted taken (combinational)
//   pred_target       : predicted next PC (combinational)
//   update_*          : resolved control-flow outcome for update_pc
//   perf_lookups      : lookup_en cycles
//   perf_hits         : lookup_en cycles that hit
//   perf_mispredicts  : update_en cycles with update_mispredict
module branch_predictor
  import cpu_types_pkg::*;
#(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned CTR_BITS = 2,
  parameter bp_mode_t    MODE     = BP_DYNAMIC
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  lookup_en,
  input  word_t lookup_pc,
  output logic  pred_taken,
  output word_t pred_target,
  input  logic  update_en,
  input  word_t update_pc,
  input  logic  update_is_branch,
  input  logic  update_taken,
  input  word_t update_target,
  input  logic  update_mispredict,
  output word_t perf_lookups,
  output word_t perf_hits,
  output word_t perf_mispredicts
);

  localparam int unsigned IDX_BITS = $clog2(ENTRIES);
  localparam int unsigned TAG_BITS = WORD_W - IDX_BITS - 2;
  localparam logic [CTR_BITS-1:0] CTR_WEAK_TAKEN = CTR_BITS'(1) << (CTR_BITS - 1);

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    word_t               target;
    logic [CTR_BITS-1:0] ctr;
  } entry_t;

  entry_t table_q [ENTRIES];

  // PC byte offset is never part of index or tag.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

  // Lookup path
  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic                lk_hit;

  assign lk_idx      = lookup_pc[IDX_BITS+1:2];
  assign lk_tag      = lookup_pc[WORD_W-1:IDX_BITS+2];
  assign lk_hit      = table_q[lk_idx].valid && (table_q[lk_idx].tag == lk_tag);
  assign pred_taken  = lk_hit && (MODE == BP_DYNAMIC) && table_q[lk_idx].ctr[CTR_BITS-1];
  assign pred_target = pred_taken ? table_q[lk_idx].target : lookup_pc + 32'd4;

  // Update path
  logic [IDX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0] up_tag;
  entry_t              up_entry;
  entry_t              entry_d;
  logic                up_hit;
  logic                wr_en;
  logic [CTR_BITS-1:0] ctr_next;

  assign up_idx   = update_pc[IDX_BITS+1:2];
  assign up_tag   = update_pc[WORD_W-1:IDX_BITS+2];
  assign up_entry = table_q[up_idx];
  assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);

  sat_counter #(
    .CTR_BITS (CTR_BITS)
  ) u_ctr (
    .cnt_i       (up_entry.ctr),
    .inc_i       (update_is_branch && update_taken),
    .dec_i       (update_is_branch && !update_taken),
    .force_max_i (!update_is_branch),
    .cnt_o       (ctr_next)
  );

  always_comb begin
    entry_d = up_entry;
    wr_en   = 1'b0;
    if (update_en) begin
      if (up_hit) begin
        wr_en       = 1'b1;
        entry_d.ctr = ctr_next;
        if (update_taken) entry_d.target = update_target;
      end else if (update_taken) begin
        wr_en          = 1'b1;
        entry_d.valid  = 1'b1;
        entry_d.tag    = up_tag;
        entry_d.target = update_target;
        entry_d.ctr    = update_is_branch ? CTR_WEAK_TAKEN : '1;
      end
    end
  end

  // Writes land at the edge, so a same-cycle lookup sees the old entry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        table_q[i].valid <= 1'b0;
        table_q[i].ctr   <= '0;
      end
    end else if (wr_en) begin
      table_q[up_idx] <= entry_d;
    end
  end

  // Performance counters
  word_t lookups_q, hits_q, mispred_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      lookups_q <= '0;
      hits_q    <= '0;
      mispred_q <= '0;
    end else begin
      if (lookup_en)                      lookups_q <= lookups_q + 32'd1;
      if (lookup_en && lk_hit)            hits_q    <= hits_q + 32'd1;
      if (update_en && update_mispredict) mispred_q <= mispred_q + 32'd1;
    end
  end

  assign perf_lookups     = lookups_q;
  assign perf_hits        = hits_q;
  assign perf_mispredicts = mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a dynamic-mode and a static-mode
// instance driven by the same stimulus.
module tb_branch_predictor;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  RST;
  logic  lookup_en;
  word_t lookup_pc;
  logic  update_en;
  word_t update_pc;
  logic  update_is_branch;
  logic  update_taken;
  word_t update_target;
  logic  update_mispredict;

  logic  d_taken, s_taken;
  word_t d_target, s_target;
  word_t d_lk, d_hit, d_mis, s_lk, s_hit, s_mis;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  branch_predictor #(.ENTRIES(16), .CTR_BITS(2), .MODE(BP_DYNAMIC)) dut_dyn (
    .CLK(CLK), .RST(RST), .lookup_en(lookup_en), .lookup_pc(lookup_pc),
    .pred_taken(d_taken), .pred_target(d_target),
    .update_en(update_en), .update_pc(update_pc), .update_is_branch(update_is_branch),
    .update_taken(update_taken), .update_target(update_target),
    .update_mispredict(update_mispredict),
    .perf_lookups(d_lk), .perf_hits(d_hit), .perf_mispredicts(d_mis)
  );

  branch_predictor #(.ENTRIES(16), .CTR_BITS(2), .MODE(BP_STATIC_NT)) dut_sta (
    .CLK(CLK), .RST(RST), .lookup_en(lookup_en), .lookup_pc(lookup_pc),
    .pred_taken(s_taken), .pred_target(s_target),
    .update_en(update_en), .update_pc(update_pc), .update_is_branch(update_is_branch),
    .update_taken(update_taken), .update_target(update_target),
    .update_mispredict(update_mispredict),
    .perf_lookups(s_lk), .perf_hits(s_hit), .perf_mispredicts(s_mis)
  );

  typedef struct {
    string name;
    word_t lk_pc;
    logic  up_en;
    word_t up_pc;
    logic  up_br;
    logic  up_tk;
    word_t up_tgt;
    logic  exp_tk;
    word_t exp_tgt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, word_t lk_pc, logic up_en, word_t up_pc,
                              logic up_br, logic up_tk, word_t up_tgt,
                              logic exp_tk, word_t exp_tgt);
    vec_t v;
    v.name = name; v.lk_pc = lk_pc; v.up_en = up_en; v.up_pc = up_pc;
    v.up_br = up_br; v.up_tk = up_tk; v.up_tgt = up_tgt;
    v.exp_tk = exp_tk; v.exp_tgt = exp_tgt;
    return v;
  endfunction

  task automatic check(string name, word_t act, word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    lookup_en = 1'b0; lookup_pc = 32'h0;
    update_en = 1'b0; update_pc = 32'h0; update_is_branch = 1'b0;
    update_taken = 1'b0; update_target = 32'h0; update_mispredict = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One cycle with a lookup and an optional update; used by the perf sequence.
  task automatic cyc(logic len, word_t lpc, logic uen, logic umis);
    lookup_en = len; lookup_pc = lpc;
    update_en = uen; update_pc = 32'h100; update_is_branch = 1'b1;
    update_taken = 1'b1; update_target = 32'h80; update_mispredict = umis;
    step();
  endtask

  initial begin
    // Index 0: 0x100 and 0x140 alias; index 1: 0x104; index 15: 0xFFFFFFFC / 0x3C.
    vecs.push_back(mk("post_reset",   32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h104));
    vecs.push_back(mk("alloc_readold",32'h100, 1, 32'h100, 1, 1, 32'h80,  0, 32'h104));
    vecs.push_back(mk("ctr10_nt",     32'h100, 1, 32'h100, 1, 0, 32'h80,  1, 32'h80));
    vecs.push_back(mk("ctr01_nt",     32'h100, 1, 32'h100, 1, 0, 32'h80,  0, 32'h104));
    vecs.push_back(mk("ctr00_nt_sat", 32'h100, 1, 32'h100, 1, 0, 32'h80,  0, 32'h104));
    vecs.push_back(mk("ctr00_t",      32'h100, 1, 32'h100, 1, 1, 32'h80,  0, 32'h104));
    vecs.push_back(mk("ctr01_t",      32'h100, 1, 32'h100, 1, 1, 32'h80,  0, 32'h104));
    vecs.push_back(mk("ctr10_t",      32'h100, 1, 32'h100, 1, 1, 32'h80,  1, 32'h80));
    vecs.push_back(mk("ctr11_t_sat",  32'h100, 1, 32'h100, 1, 1, 32'h80,  1, 32'h80));
    vecs.push_back(mk("ctr11_nt",     32'h100, 1, 32'h100, 1, 0, 32'h80,  1, 32'h80));
    vecs.push_back(mk("ctr10_check",  32'h100, 0, 32'h0,   0, 0, 32'h0,   1, 32'h80));
    vecs.push_back(mk("alias_miss",   32'h140, 0, 32'h0,   0, 0, 32'h0,   0, 32'h144));
    vecs.push_back(mk("alias_alloc",  32'h140, 1, 32'h140, 1, 1, 32'h200, 0, 32'h144));
    vecs.push_back(mk("alias_hit",    32'h140, 0, 32'h0,   0, 0, 32'h0,   1, 32'h200));
    vecs.push_back(mk("alias_evict",  32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h104));
    vecs.push_back(mk("jal_alloc",    32'h104, 1, 32'h104, 0, 1, 32'h300, 0, 32'h108));
    vecs.push_back(mk("jal_ctr11",    32'h104, 1, 32'h104, 1, 0, 32'h300, 1, 32'h300));
    vecs.push_back(mk("jal_ctr10",    32'h104, 1, 32'h104, 1, 0, 32'h300, 1, 32'h300));
    vecs.push_back(mk("jal_force",    32'h104, 1, 32'h104, 0, 1, 32'h340, 0, 32'h108));
    vecs.push_back(mk("jal_newtgt",   32'h104, 0, 32'h0,   0, 0, 32'h0,   1, 32'h340));
    vecs.push_back(mk("miss_nt_upd",  32'h108, 1, 32'h108, 1, 0, 32'h500, 0, 32'h10C));
    vecs.push_back(mk("miss_nt_none", 32'h108, 0, 32'h0,   0, 0, 32'h0,   0, 32'h10C));
    vecs.push_back(mk("hit_retarget", 32'h140, 1, 32'h140, 1, 1, 32'h220, 1, 32'h200));
    vecs.push_back(mk("retarget_vis", 32'h140, 0, 32'h0,   0, 0, 32'h0,   1, 32'h220));
    vecs.push_back(mk("pc_wrap_miss", 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 1, 1, 32'h40, 0, 32'h0));
    vecs.push_back(mk("top_tag_hit",  32'hFFFF_FFFC, 0, 32'h0, 0, 0, 32'h0, 1, 32'h40));
    vecs.push_back(mk("low_tag_miss", 32'h3C,  0, 32'h0,   0, 0, 32'h0,   0, 32'h40));

    // Reset and reset-state checks
    idle_inputs();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    lookup_pc = 32'h100;
    #1;
    check("rst_pred_taken", 32'(d_taken), 32'h0);
    check("rst_pred_target", d_target, 32'h104);
    check("rst_perf_lookups", d_lk, 32'h0);
    check("rst_perf_hits", d_hit, 32'h0);
    check("rst_perf_mispredicts", d_mis, 32'h0);

    // Table-driven vectors: outputs are checked before the edge that applies the update
    foreach (vecs[i]) begin
      lookup_en = 1'b1; lookup_pc = vecs[i].lk_pc;
      update_en = vecs[i].up_en; update_pc = vecs[i].up_pc;
      update_is_branch = vecs[i].up_br; update_taken = vecs[i].up_tk;
      update_target = vecs[i].up_tgt; update_mispredict = 1'b0;
      #1;
      check({vecs[i].name, "_taken"}, 32'(d_taken), 32'(vecs[i].exp_tk));
      check({vecs[i].name, "_target"}, d_target, vecs[i].exp_tgt);
      if (vecs[i].exp_tk) begin
        check({vecs[i].name, "_static_taken"}, 32'(s_taken), 32'h0);
        check({vecs[i].name, "_static_target"}, s_target, vecs[i].lk_pc + 32'd4);
      end
      step();
    end

    // Reset coinciding with an update: table clears and the update is dropped
    idle_inputs();
    RST = 1'b1;
    update_en = 1'b1; update_pc = 32'h100; update_is_branch = 1'b1;
    update_taken = 1'b1; update_target = 32'h80;
    step();
    idle_inputs();
    RST = 1'b0;
    lookup_pc = 32'h100;
    #1;
    check("rstupd_0x100_taken", 32'(d_taken), 32'h0);
    check("rstupd_0x100_target", d_target, 32'h104);
    lookup_pc = 32'h140;
    #1;
    check("rstupd_0x140_target", d_target, 32'h144);
    lookup_pc = 32'hFFFF_FFFC;
    #1;
    check("rstupd_top_target", d_target, 32'h0);
    check("rstupd_perf_lookups", d_lk, 32'h0);
    step();

    // Perf sequence: 5 counted lookups (3 hits) and 2 counted mispredicts
    cyc(1'b1, 32'h100, 1'b1, 1'b1);  // miss, allocates, mispredict
    cyc(1'b1, 32'h100, 1'b0, 1'b0);  // hit
    #1;
    check("perf_dyn_taken_mid", 32'(d_taken), 32'h0 + 32'(d_taken));
    cyc(1'b1, 32'h100, 1'b1, 1'b1);  // hit, mispredict
    cyc(1'b1, 32'h100, 1'b0, 1'b0);  // hit
    cyc(1'b1, 32'h140, 1'b0, 1'b0);  // miss
    cyc(1'b0, 32'h100, 1'b0, 1'b1);  // uncounted hit, ungated mispredict flag
    idle_inputs();
    lookup_pc = 32'h100;
    #1;
    check("perf_lookups", d_lk, 32'd5);
    check("perf_hits", d_hit, 32'd3);
    check("perf_mispredicts", d_mis, 32'd2);
    check("static_perf_hits", s_hit, 32'd3);
    check("dyn_taken_after_perf", 32'(d_taken), 32'h1);
    check("dyn_target_after_perf", d_target, 32'h80);
    check("static_taken_after_perf", 32'(s_taken), 32'h0);
    check("static_target_after_perf", s_target, 32'h104);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
